// File: rtl/muldiv_seq_pkg.sv
// Shared op codes, FSM state encoding and default operand width for muldiv_seq.
package muldiv_seq_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [2:0] MULDIV_OP_MULT  = 3'd0;
    localparam logic [2:0] MULDIV_OP_MULTU = 3'd1;
    localparam logic [2:0] MULDIV_OP_DIV   = 3'd2;
    localparam logic [2:0] MULDIV_OP_DIVU  = 3'd3;
    localparam logic [2:0] MULDIV_OP_MADD  = 3'd4;
    localparam logic [2:0] MULDIV_OP_MADDU = 3'd5;
    localparam logic [2:0] MULDIV_OP_MSUB  = 3'd6;
    localparam logic [2:0] MULDIV_OP_MSUBU = 3'd7;

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StAcc,
        StDiv,
        StDzero,
        StDone
    } muldiv_state_e;

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == MULDIV_OP_DIV) || (op == MULDIV_OP_DIVU);
    endfunction

    function automatic logic op_mul_signed(input logic [2:0] op);
        return (op == MULDIV_OP_MULT) || (op == MULDIV_OP_MADD) || (op == MULDIV_OP_MSUB);
    endfunction

endpackage

// File: rtl/div_restoring.sv
// Iterative restoring divider: one quotient bit per cycle over XLEN cycles, sign fixed on output.
module div_restoring #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            annul,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            signed_op,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int unsigned CW = $clog2(XLEN + 1);

    logic            busy_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] quo_q, rem_q, dvs_q;
    logic            qneg_q, rneg_q;

    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;
    logic [XLEN-1:0] quo_d, rem_d;
    logic            unused_diff_bit;

    // Quotient register doubles as the dividend shifter.
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign diff    = {1'b0, shifted} - {2'b00, dvs_q};
    assign quo_d   = {quo_q[XLEN-2:0], ~diff[XLEN+1]};
    assign rem_d   = diff[XLEN+1] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign unused_diff_bit = diff[XLEN];

    // Outputs present the result of the step being taken while done is high.
    assign done      = busy_q & (cnt_q == CW'(XLEN - 1));
    assign quotient  = qneg_q ? -quo_d : quo_d;
    assign remainder = rneg_q ? -rem_d : rem_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else if (annul) begin
            busy_q <= 1'b0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= (signed_op && dividend[XLEN-1]) ? -dividend : dividend;
            dvs_q  <= (signed_op && divisor[XLEN-1]) ? -divisor : divisor;
            qneg_q <= signed_op & (dividend[XLEN-1] ^ divisor[XLEN-1]);
            rneg_q <= signed_op & dividend[XLEN-1];
        end else if (busy_q) begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q + CW'(1);
            if (done) busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential multiply/divide unit beside EX. Define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU;
// without it those ops complete with a zero result.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEFAULT,
    parameter int unsigned MUL_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [XLEN-1:0]   opdata1_i,
    input  logic [XLEN-1:0]   opdata2_i,
    input  logic [XLEN-1:0]   hi_i,
    input  logic [XLEN-1:0]   lo_i,
    input  logic              annul_i,
    output logic              stallreq_o,
    output logic              busy_o,
    output logic              ready_o,
    output logic [2*XLEN-1:0] result_o,
    output logic              div_by_zero_o
);
    localparam int unsigned RW   = 2 * XLEN;
    localparam int unsigned CntW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

    muldiv_state_e   state_q, state_d;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [CntW-1:0] cnt_q;
    logic [RW-1:0]   result_q, result_d;
    logic            dbz_q;

    logic            accept, div_start, mul_last, op_illegal, to_acc, mul_neg;
    logic            div_done;
    logic [XLEN-1:0] div_quo, div_rem, a_mag, b_mag;
    logic [RW-1:0]   prod_mag, prod;

    assign accept    = (state_q == StIdle) & start_i & ~annul_i;
    assign div_start = accept & op_is_div(op_i) & (opdata2_i != '0);

    // Unsigned magnitude product; sign restored afterwards.
    assign mul_neg  = op_mul_signed(op_q) & (a_q[XLEN-1] ^ b_q[XLEN-1]);
    assign a_mag    = (op_mul_signed(op_q) && a_q[XLEN-1]) ? -a_q : a_q;
    assign b_mag    = (op_mul_signed(op_q) && b_q[XLEN-1]) ? -b_q : b_q;
    assign prod_mag = RW'(a_mag) * RW'(b_mag);
    assign prod     = op_illegal ? '0 : (mul_neg ? -prod_mag : prod_mag);
    assign mul_last = op_illegal | (cnt_q == CntW'(MUL_STAGES - 1));

`ifdef MULDIV_MADD_EN
    logic [XLEN-1:0] hi_q, lo_q;
    logic [RW-1:0]   prod_q, acc;

    assign op_illegal = 1'b0;
    assign to_acc     = op_q[2];
    // op bit 1 selects MSUB* over MADD*.
    assign acc        = op_q[1] ? ({hi_q, lo_q} - prod_q) : ({hi_q, lo_q} + prod_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            prod_q <= '0;
        end else begin
            if (accept) begin
                hi_q <= hi_i;
                lo_q <= lo_i;
            end
            if (state_q == StMul) prod_q <= prod;
        end
    end
`else
    logic unused_acc_in;
    assign unused_acc_in = ^{hi_i, lo_i};
    assign op_illegal    = op_q[2];
    assign to_acc        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (op_is_div(op_i)) state_d = (opdata2_i == '0) ? StDzero : StDiv;
                    else                 state_d = StMul;
                end
            end
            StMul:   if (mul_last) state_d = to_acc ? StAcc : StDone;
`ifdef MULDIV_MADD_EN
            StAcc:   state_d = StDone;
`endif
            StDiv:   if (div_done) state_d = StDone;
            StDzero: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (annul_i) state_d = StIdle;
    end

    // Result only loads on the way into DONE, so an annulled op leaves it untouched.
    always_comb begin
        result_d = result_q;
        if (state_d == StDone && state_q != StDone) begin
            unique case (state_q)
                StMul:   result_d = prod;
`ifdef MULDIV_MADD_EN
                StAcc:   result_d = acc;
`endif
                StDiv:   result_d = {div_rem, div_quo};
                StDzero: result_d = {a_q, {XLEN{1'b1}}};
                default: result_d = result_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            if (accept) begin
                op_q  <= op_i;
                a_q   <= opdata1_i;
                b_q   <= opdata2_i;
                cnt_q <= '0;
                dbz_q <= 1'b0;
            end else if (state_q == StMul) begin
                cnt_q <= cnt_q + CntW'(1);
            end
            if (state_q == StDzero && state_d == StDone) dbz_q <= 1'b1;
        end
    end

    div_restoring #(
        .XLEN(XLEN)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .annul     (annul_i),
        .dividend  (opdata1_i),
        .divisor   (opdata2_i),
        .signed_op (op_i == MULDIV_OP_DIV),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign stallreq_o    = (start_i & (state_q == StIdle)) |
                           (state_q inside {StMul, StDiv, StAcc});
    assign busy_o        = (state_q != StIdle) && (state_q != StDone);
    assign ready_o       = (state_q == StDone) & ~annul_i;
    assign result_o      = result_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: vector table pushed through a result scoreboard, plus annul and
// held-start sequences.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned MUL_STAGES = 2;
    localparam int          NVEC       = 19;
`ifdef MULDIV_MADD_EN
    localparam bit MaddEn = 1'b1;
`else
    localparam bit MaddEn = 1'b0;
`endif
    localparam int LatMul = MUL_STAGES + 1;
    localparam int LatDiv = XLEN + 1;
    localparam int LatAcc = MaddEn ? MUL_STAGES + 2 : 0;  // 0: latency not compared

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic [2:0]  op    = '0;
    logic [31:0] d1 = '0, d2 = '0, hi = '0, lo = '0;
    logic        stallreq, busy, ready, dbz;
    logic [63:0] result;

    muldiv_seq #(
        .XLEN       (XLEN),
        .MUL_STAGES (MUL_STAGES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .op_i          (op),
        .opdata1_i     (d1),
        .opdata2_i     (d2),
        .hi_i          (hi),
        .lo_i          (lo),
        .annul_i       (annul),
        .stallreq_o    (stallreq),
        .busy_o        (busy),
        .ready_o       (ready),
        .result_o      (result),
        .div_by_zero_o (dbz)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, h, l;
        logic [63:0] res;
        logic        dz;
        int          lat;
    } vec_t;

    typedef struct {
        string       name;
        logic [63:0] res;
        logic        dz;
        int          lat;
        int          acc;
    } exp_t;

    vec_t vecs[NVEC];
    exp_t sb[$];
    int   checks = 0, passed = 0, ready_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    function automatic vec_t mk(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] h, input logic [31:0] l,
                                input logic [63:0] res, input logic dz, input int lat);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.h = h; v.l = l; v.res = res; v.dz = dz; v.lat = lat;
        return v;
    endfunction

    // Scoreboard: each ready pulse pops one expected record.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && ready === 1'b1) begin
            ready_cnt++;
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_ready: got ready_o=1 with nothing pending, required 0");
            end else begin
                e = sb.pop_front();
                check({e.name, "_result"}, result, e.res);
                check({e.name, "_dbz"}, 64'(dbz), 64'(e.dz));
                if (e.lat != 0) check({e.name, "_latency"}, 64'(cyc - e.acc + 1), 64'(e.lat));
            end
        end
    end

    task automatic push_on_accept(input string name, input logic [63:0] res, input logic dz,
                                  input int lat, input bit drop);
        exp_t e;
        @(posedge clk);
        #1;
        if (drop) start = 1'b0;
        e.name = name; e.res = res; e.dz = dz; e.lat = lat; e.acc = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input int bound, input string name);
        int n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL %s_timeout: got %0d results outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          c0, r0;
        logic [63:0] last_res;

        vecs[0]  = mk(MULDIV_OP_MULT,  32'hFFFFFFFE, 32'd3, 0, 0, 64'hFFFFFFFF_FFFFFFFA, 0, LatMul);
        vecs[1]  = mk(MULDIV_OP_MULTU, 32'hFFFFFFFE, 32'd3, 0, 0, 64'h00000002_FFFFFFFA, 0, LatMul);
        vecs[2]  = mk(MULDIV_OP_MULT,  32'h80000000, 32'h80000000, 0, 0, 64'h40000000_00000000, 0,
                      LatMul);
        vecs[3]  = mk(MULDIV_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 64'hFFFFFFFE_00000001, 0,
                      LatMul);
        vecs[4]  = mk(MULDIV_OP_MULT,  32'd7, 32'hFFFFFFFB, 0, 0, 64'hFFFFFFFF_FFFFFFDD, 0, LatMul);
        vecs[5]  = mk(MULDIV_OP_DIVU,  32'd100, 32'd7, 0, 0, 64'h00000002_0000000E, 0, LatDiv);
        vecs[6]  = mk(MULDIV_OP_DIV,   32'hFFFFFFF9, 32'd2, 0, 0, 64'hFFFFFFFF_FFFFFFFD, 0, LatDiv);
        vecs[7]  = mk(MULDIV_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 0, 0, 64'h00000000_80000000, 0,
                      LatDiv);
        vecs[8]  = mk(MULDIV_OP_DIV,   32'd7, 32'hFFFFFFFE, 0, 0, 64'h00000001_FFFFFFFD, 0, LatDiv);
        vecs[9]  = mk(MULDIV_OP_DIVU,  32'hFFFFFFFF, 32'd1, 0, 0, 64'h00000000_FFFFFFFF, 0, LatDiv);
        vecs[10] = mk(MULDIV_OP_DIVU,  32'd5, 32'd0, 0, 0, 64'h00000005_FFFFFFFF, 1, 2);
        vecs[11] = mk(MULDIV_OP_DIV,   32'h12345678, 32'd0, 0, 0, 64'h12345678_FFFFFFFF, 1, 2);
        vecs[12] = mk(MULDIV_OP_MADD,  32'd3, 32'd4, 32'd0, 32'd10,
                      MaddEn ? 64'd22 : 64'd0, 0, LatAcc);
        vecs[13] = mk(MULDIV_OP_MSUB,  32'd3, 32'd4, 32'd0, 32'd10,
                      MaddEn ? 64'hFFFFFFFF_FFFFFFFE : 64'd0, 0, LatAcc);
        vecs[14] = mk(MULDIV_OP_MADD,  32'hFFFFFFFF, 32'd5, 32'd0, 32'd0,
                      MaddEn ? 64'hFFFFFFFF_FFFFFFFB : 64'd0, 0, LatAcc);
        vecs[15] = mk(MULDIV_OP_MADDU, 32'd2, 32'd3, 32'd1, 32'd0,
                      MaddEn ? 64'h00000001_00000006 : 64'd0, 0, LatAcc);
        vecs[16] = mk(MULDIV_OP_MSUBU, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd5,
                      MaddEn ? 64'hFFFFFFFF_00000006 : 64'd0, 0, LatAcc);
        vecs[17] = mk(MULDIV_OP_DIVU,  32'd3, 32'd5, 0, 0, 64'h00000003_00000000, 0, LatDiv);
        vecs[18] = mk(MULDIV_OP_DIV,   32'hFFFFFFF8, 32'd3, 0, 0, 64'hFFFFFFFE_FFFFFFFE, 0, LatDiv);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_stallreq", 64'(stallreq), 64'd0);
        check("reset_dbz", 64'(dbz), 64'd0);
        check("reset_result", result, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            start = 1'b1; op = vecs[i].op; d1 = vecs[i].a; d2 = vecs[i].b;
            hi = vecs[i].h; lo = vecs[i].l;
            push_on_accept($sformatf("vec%0d", i), vecs[i].res, vecs[i].dz, vecs[i].lat, 1'b1);
            wait_drain(100, $sformatf("vec%0d", i));
        end
        last_res = vecs[NVEC-1].res;

        // DIV annulled on the cycle-10 edge, then a MULT accepted right away
        @(negedge clk);
        start = 1'b1; op = MULDIV_OP_DIV; d1 = 32'd1000; d2 = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        c0 = cyc;
        repeat (10) @(negedge clk);
        check("annul_pre_busy", 64'(busy), 64'd1);
        check("annul_pre_stallreq", 64'(stallreq), 64'd1);
        check("annul_pre_cycle", 64'(cyc - c0), 64'd9);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        #1;
        check("annul_busy", 64'(busy), 64'd0);
        check("annul_stallreq", 64'(stallreq), 64'd0);
        check("annul_ready", 64'(ready), 64'd0);
        check("annul_result_held", result, last_res);
        start = 1'b1; op = MULDIV_OP_MULT; d1 = 32'd5; d2 = 32'd6;
        #1;
        check("post_annul_stallreq", 64'(stallreq), 64'd1);
        push_on_accept("post_annul_mult", 64'd30, 1'b0, LatMul, 1'b1);
        wait_drain(100, "post_annul_mult");

        // start together with annul in IDLE is not accepted
        r0 = ready_cnt;
        @(negedge clk);
        start = 1'b1; annul = 1'b1; op = MULDIV_OP_MULTU; d1 = 32'd2; d2 = 32'd2;
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        #1;
        check("annul_start_busy", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        check("annul_start_pulses", 64'(ready_cnt - r0), 64'd0);

        // start held through the whole op gives exactly one pulse
        r0 = ready_cnt;
        @(negedge clk);
        start = 1'b1; op = MULDIV_OP_DIVU; d1 = 32'd100; d2 = 32'd7;
        push_on_accept("held_start", 64'h00000002_0000000E, 1'b0, LatDiv, 1'b0);
        wait_drain(100, "held_start");
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("held_start_pulses", 64'(ready_cnt - r0), 64'd1);
        check("held_start_idle", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
